// File: rtl/compute_r_bins_mt.sv
// compute_r_bins_mt: multi-theta, time-multiplexed r-bin calculator for the
// LSF Hough stage. Each accepted hit is swept over NTHETA angles, LANES per
// cycle. Each group of LANES angles leaves as one output beat.
// Pipeline: stage 0 (hit hold + group sweep), stage 1 (products),
//           stage 2 (align, sum, bin, range check -> output registers).
// Build option: define COMPUTE_R_BINS_SAT_EN to clamp out-of-range bins
// to 0 / RBINS-1 (flagged valid) instead of reporting them as invalid.
//
// state   | meaning
// S_IDLE  | no hit held, stage 0 empty
// S_SWEEP | hit held, grp_cnt selects the group issued this cycle
module compute_r_bins_mt #(
    parameter int W_X       = 16,
    parameter int DECB_X    = 4,
    parameter int W_Y       = 16,
    parameter int DECB_Y    = 4,
    parameter int W_R       = 22,
    parameter int IW_R      = 16,
    parameter int W_OUT     = 18,
    parameter int IW_OUT    = 1,
    parameter int NTHETA    = 8,
    parameter int LANES     = 2,
    parameter int RBINS     = 128,
    parameter int BIN_SHIFT = 5,
    parameter int W_TAG     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  hit_vld,
    output logic                                  hit_rdy,
    input  logic signed [W_X-1:0]                 hit_x,
    input  logic signed [W_Y-1:0]                 hit_y,
    input  logic signed [W_R-1:0]                 hit_r_offset,
    input  logic [W_TAG-1:0]                      hit_tag,
    input  logic [NTHETA*W_OUT-1:0]               cos_lut,
    input  logic [NTHETA*W_OUT-1:0]               sin_lut,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [((NTHETA/LANES) > 1 ? $clog2(NTHETA/LANES) : 1)-1:0] out_grp,
    output logic                                  out_last,
    output logic [W_TAG-1:0]                      out_tag,
    output logic [LANES*$clog2(RBINS)-1:0]        out_bin,
    output logic [LANES-1:0]                      out_bin_vld
);

    localparam int NG     = NTHETA / LANES;
    localparam int GW     = (NG > 1) ? $clog2(NG) : 1;
    localparam int W_BIN  = $clog2(RBINS);
    localparam int FR_R   = W_R - IW_R;
    localparam int FR_OUT = W_OUT - IW_OUT;
    localparam int XS     = DECB_X + FR_OUT - FR_R;
    localparam int YS     = DECB_Y + FR_OUT - FR_R;
    localparam int P_X    = W_X + W_OUT;
    localparam int P_Y    = W_Y + W_OUT;
    localparam int W_MXY  = (P_X > P_Y) ? P_X : P_Y;
    localparam int W_MAX  = (W_MXY > W_R) ? W_MXY : W_R;
    // two guard bits: the sum of three terms can never wrap
    localparam int W_SUM  = W_MAX + 2;
    localparam logic signed [W_SUM-1:0] RBINS_S = W_SUM'(RBINS);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                    state_q, state_d;
    logic [GW-1:0]             grp_cnt;
    logic                      en, accept, grp_last;

    logic signed [W_X-1:0]     s0_x;
    logic signed [W_Y-1:0]     s0_y;
    logic signed [W_R-1:0]     s0_roff;
    logic [W_TAG-1:0]          s0_tag;
    logic signed [W_OUT-1:0]   cos_sel [LANES];
    logic signed [W_OUT-1:0]   sin_sel [LANES];

    logic                      s1_vld, s1_last;
    logic [GW-1:0]             s1_grp;
    logic [W_TAG-1:0]          s1_tag;
    logic signed [W_R-1:0]     s1_roff;
    logic signed [P_X-1:0]     s1_xc [LANES];
    logic signed [P_Y-1:0]     s1_ys [LANES];

    logic signed [W_SUM-1:0]   r_sum [LANES];
    logic signed [W_SUM-1:0]   b_val [LANES];
    logic [W_BIN-1:0]          b_bin [LANES];
    logic [LANES-1:0]          b_ok;

    // Sweep control: handshake, stall enable and next state
    always_comb begin
        state_d  = state_q;
        en       = !out_vld || out_rdy;
        grp_last = (grp_cnt == GW'(NG - 1));
        hit_rdy  = rst_n && en && ((state_q == S_IDLE) || grp_last);
        accept   = hit_vld && hit_rdy;
        if (en) begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_SWEEP;
                S_SWEEP: if (grp_last && !accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register and group counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grp_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (en) begin
                if (accept || grp_last)
                    grp_cnt <= '0;
                else if (state_q == S_SWEEP)
                    grp_cnt <= grp_cnt + GW'(1);
            end
        end
    end

    // Stage 0: latch the hit on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_x    <= '0;
            s0_y    <= '0;
            s0_roff <= '0;
            s0_tag  <= '0;
        end else if (accept) begin
            s0_x    <= hit_x;
            s0_y    <= hit_y;
            s0_roff <= hit_r_offset;
            s0_tag  <= hit_tag;
        end
    end

    // Pick the sin/cos words of the current group for each lane
    always_comb begin
        int idx;
        idx = 0;
        for (int l = 0; l < LANES; l++) begin
            idx        = int'(grp_cnt) * LANES + l;
            cos_sel[l] = cos_lut[idx*W_OUT +: W_OUT];
            sin_sel[l] = sin_lut[idx*W_OUT +: W_OUT];
        end
    end

    // Stage 1: full-precision products per lane
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_grp  <= '0;
            s1_tag  <= '0;
            s1_roff <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_xc[l] <= '0;
                s1_ys[l] <= '0;
            end
        end else if (en) begin
            s1_vld  <= (state_q == S_SWEEP);
            s1_last <= grp_last;
            s1_grp  <= grp_cnt;
            s1_tag  <= s0_tag;
            s1_roff <= s0_roff;
            for (int l = 0; l < LANES; l++) begin
                s1_xc[l] <= P_X'(s0_x) * P_X'(cos_sel[l]);
                s1_ys[l] <= P_Y'(s0_y) * P_Y'(sin_sel[l]);
            end
        end
    end

    // Stage 2 combinational: align to r fraction, sum, bin and range test
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            r_sum[l] = W_SUM'(s1_xc[l] >>> XS) + W_SUM'(s1_ys[l] >>> YS)
                     + W_SUM'(s1_roff);
            b_val[l] = r_sum[l] >>> BIN_SHIFT;
            b_ok[l]  = !b_val[l][W_SUM-1] && (b_val[l] < RBINS_S);
`ifdef COMPUTE_R_BINS_SAT_EN
            if (b_ok[l])
                b_bin[l] = b_val[l][W_BIN-1:0];
            else if (b_val[l][W_SUM-1])
                b_bin[l] = '0;
            else
                b_bin[l] = W_BIN'(RBINS - 1);
`else
            b_bin[l] = b_ok[l] ? b_val[l][W_BIN-1:0] : '0;
`endif
        end
    end

    // Output registers; fields are zeroed on bubbles so idle outputs read 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
            out_grp     <= '0;
            out_tag     <= '0;
            out_bin     <= '0;
            out_bin_vld <= '0;
        end else if (en) begin
            out_vld  <= s1_vld;
            out_last <= s1_vld && s1_last;
            out_grp  <= s1_vld ? s1_grp : '0;
            out_tag  <= s1_vld ? s1_tag : '0;
            for (int l = 0; l < LANES; l++) begin
                out_bin[l*W_BIN +: W_BIN] <= s1_vld ? b_bin[l] : '0;
`ifdef COMPUTE_R_BINS_SAT_EN
                out_bin_vld[l] <= s1_vld;
`else
                out_bin_vld[l] <= s1_vld && b_ok[l];
`endif
            end
        end
    end

endmodule
